// File: rtl/l2_cache_wb.sv
// l2_cache_wb: set-associative write-back, write-allocate L2 cache serving L1-sized slices of larger lines.
module l2_cache_wb #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDR_WIDTH    = 32,
  parameter int CACHE_SIZE    = 1024,
  parameter int BLOCK_SIZE    = 32,
  parameter int NUM_WAYS      = 4,
  parameter int L1_BLOCK_SIZE = 16,
  parameter int HIT_LATENCY   = 10,
  parameter int REPL_POLICY   = 0
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic [3:0]                            random_num,
  input  logic [ADDR_WIDTH-1:0]                 l2_cache_addr,
  input  logic [L1_BLOCK_SIZE*DATA_WIDTH-1:0]   l2_cache_data_in,
  output logic [L1_BLOCK_SIZE*DATA_WIDTH-1:0]   l2_cache_data_out,
  input  logic                                  l2_cache_read,
  input  logic                                  l2_cache_write,
  output logic                                  l2_cache_ready,
  output logic                                  l2_hit,
  output logic [ADDR_WIDTH-1:0]                 mem_addr,
  output logic [BLOCK_SIZE*DATA_WIDTH-1:0]      mem_data_out,
  input  logic [BLOCK_SIZE*DATA_WIDTH-1:0]      mem_data_in,
  output logic                                  mem_read,
  output logic                                  mem_write,
  input  logic                                  mem_ready
);
  localparam int NUM_SETS = CACHE_SIZE / (BLOCK_SIZE * NUM_WAYS);
  localparam int OW = $clog2(BLOCK_SIZE);
  localparam int IW = $clog2(NUM_SETS);
  localparam int TW = ADDR_WIDTH - OW - IW;
  localparam int WW = NUM_WAYS > 1 ? $clog2(NUM_WAYS) : 1;
  localparam int LW = BLOCK_SIZE * DATA_WIDTH;
  localparam int SW = L1_BLOCK_SIZE * DATA_WIDTH;

  typedef enum logic [1:0] {IDLE, COMPARE_TAG, WRITE_BACK, ALLOCATE} state_t;

  state_t                             state;
  logic [7:0]                         cnt;
  logic [ADDR_WIDTH-1:0]              addr_q;
  logic [SW-1:0]                      din_q;
  logic                               wr_q;
  logic [WW-1:0]                      vic_q;
  logic [NUM_SETS-1:0][NUM_WAYS-1:0]  valid;
  logic [NUM_SETS-1:0][NUM_WAYS-1:0]  dirty;
  logic [NUM_SETS-1:0][WW-1:0]        rr;
  logic [LW-1:0]                      data_mem [NUM_SETS][NUM_WAYS];
  logic [TW-1:0]                      tag_mem  [NUM_SETS][NUM_WAYS];

  logic [TW-1:0]  tag_q;
  logic [IW-1:0]  idx;
  logic [31:0]    sl_base;
  logic           hit;
  logic           inv;
  logic [WW-1:0]  hit_way;
  logic [WW-1:0]  inv_way;
  logic [WW-1:0]  victim;
  logic [LW-1:0]  cur_line;
  logic [LW-1:0]  wline;
  logic           we;
  logic [WW-1:0]  we_way;

  assign tag_q   = addr_q[ADDR_WIDTH-1:OW+IW];
  assign idx     = addr_q[OW+IW-1:OW];
  assign sl_base = 32'((int'(addr_q[OW-1:0]) / L1_BLOCK_SIZE) * SW);

  always_comb begin
    hit     = 1'b0;
    inv     = 1'b0;
    hit_way = '0;
    inv_way = '0;
    // descending scan so the lowest matching/invalid way wins
    for (int w = NUM_WAYS - 1; w >= 0; w--) begin
      if (valid[idx][w] && tag_mem[idx][w] == tag_q) begin
        hit     = 1'b1;
        hit_way = WW'(w);
      end
      if (!valid[idx][w]) begin
        inv     = 1'b1;
        inv_way = WW'(w);
      end
    end
    victim   = inv ? inv_way : REPL_POLICY == 1 ? rr[idx] : WW'(random_num % NUM_WAYS);
    cur_line = data_mem[idx][hit_way];
    wline    = state == ALLOCATE ? mem_data_in : cur_line;
    wline[sl_base +: SW] = din_q;
  end

  assign we     = (state == COMPARE_TAG && cnt == 8'd0 && hit && wr_q) || (state == ALLOCATE && mem_ready);
  assign we_way = state == ALLOCATE ? vic_q : hit_way;

  always_ff @(posedge clk) begin
    if (we) data_mem[idx][we_way] <= (state == ALLOCATE && !wr_q) ? mem_data_in : wline;
    if (state == ALLOCATE && mem_ready) tag_mem[idx][vic_q] <= tag_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state             <= IDLE;
      cnt               <= '0;
      addr_q            <= '0;
      din_q             <= '0;
      wr_q              <= 1'b0;
      vic_q             <= '0;
      valid             <= '0;
      dirty             <= '0;
      rr                <= '0;
      l2_cache_data_out <= '0;
      l2_cache_ready    <= 1'b0;
      l2_hit            <= 1'b0;
      mem_addr          <= '0;
      mem_data_out      <= '0;
      mem_read          <= 1'b0;
      mem_write         <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          l2_cache_ready <= 1'b0;
          mem_read       <= 1'b0;
          mem_write      <= 1'b0;
          if ((l2_cache_read || l2_cache_write) && !l2_cache_ready) begin
            addr_q <= l2_cache_addr;
            din_q  <= l2_cache_data_in;
            wr_q   <= l2_cache_write;
            cnt    <= 8'(HIT_LATENCY);
            state  <= COMPARE_TAG;
          end
        end
        COMPARE_TAG: begin
          if (cnt != 8'd0) cnt <= cnt - 8'd1;
          else if (hit) begin
            if (wr_q) dirty[idx][hit_way] <= 1'b1;
            else l2_cache_data_out <= cur_line[sl_base +: SW];
            l2_cache_ready <= 1'b1;
            l2_hit         <= 1'b1;
            state          <= IDLE;
          end else begin
            vic_q <= victim;
            if (dirty[idx][victim]) begin
              mem_addr     <= {tag_mem[idx][victim], idx, OW'(0)};
              mem_data_out <= data_mem[idx][victim];
              mem_write    <= 1'b1;
              state        <= WRITE_BACK;
            end else begin
              mem_addr <= {tag_q, idx, OW'(0)};
              mem_read <= 1'b1;
              state    <= ALLOCATE;
            end
          end
        end
        WRITE_BACK: if (mem_ready) begin
          dirty[idx][vic_q] <= 1'b0;
          mem_write         <= 1'b0;
          mem_read          <= 1'b1;
          mem_addr          <= {tag_q, idx, OW'(0)};
          state             <= ALLOCATE;
        end
        ALLOCATE: if (mem_ready) begin
          valid[idx][vic_q] <= 1'b1;
          dirty[idx][vic_q] <= wr_q;
          if (!wr_q) l2_cache_data_out <= mem_data_in[sl_base +: SW];
          if (&valid[idx]) rr[idx] <= (rr[idx] + WW'(1)) & WW'(NUM_WAYS - 1);
          l2_cache_ready <= 1'b1;
          l2_hit         <= 1'b0;
          mem_read       <= 1'b0;
          state          <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_l2_cache_wb.sv
// tb_l2_cache_wb: directed checks of hits, refills, dirty writebacks, reset abort and slow memory.
module tb_l2_cache_wb;
  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [3:0]   random_num = 4'd0;
  logic [31:0]  addr = '0;
  logic [127:0] din = '0;
  logic [127:0] dout;
  logic         read = 1'b0;
  logic         write = 1'b0;
  logic         ready;
  logic         hit;
  logic [31:0]  mem_addr;
  logic [255:0] mdo;
  logic [255:0] mdi = '0;
  logic         mem_read;
  logic         mem_write;
  logic         mem_ready = 1'b0;

  l2_cache_wb #(.CACHE_SIZE(64), .BLOCK_SIZE(8), .NUM_WAYS(2), .L1_BLOCK_SIZE(4),
                .HIT_LATENCY(2), .REPL_POLICY(1)) dut (
    .clk(clk), .rst_n(rst_n), .random_num(random_num), .l2_cache_addr(addr),
    .l2_cache_data_in(din), .l2_cache_data_out(dout), .l2_cache_read(read),
    .l2_cache_write(write), .l2_cache_ready(ready), .l2_hit(hit), .mem_addr(mem_addr),
    .mem_data_out(mdo), .mem_data_in(mdi), .mem_read(mem_read), .mem_write(mem_write),
    .mem_ready(mem_ready));

  always #5 clk = ~clk;

  logic [31:0]  bmem [0:255];
  int           vec = 0;
  int           bad = 0;
  int           n_rd, n_wr, edge_no, rd_hi;
  logic [31:0]  rd_addr, wb_addr;
  logic [255:0] wb_data;
  logic [127:0] got_data;
  logic         got_hit, done, pulse_ok, early_ready;

  function automatic logic [127:0] w4(input int a, b, c, d);
    return {d[31:0], c[31:0], b[31:0], a[31:0]};
  endfunction

  function automatic logic [255:0] w8(input int a, b, c, d, e, f, g, h);
    return {w4(e, f, g, h), w4(a, b, c, d)};
  endfunction

  // drives one request and acts as main memory, answering after `delay` cycles
  task automatic req(input logic [31:0] a, input logic rd, input logic wr, input logic [127:0] d, input int delay);
    int w = 0;
    n_rd = 0; n_wr = 0; rd_hi = 0; done = 0; pulse_ok = 0; early_ready = 0; edge_no = -1;
    @(negedge clk);
    addr = a; read = rd; write = wr; din = d;
    for (int cyc = 1; cyc <= 300 && !done; cyc++) begin
      @(negedge clk);
      if (mem_read) rd_hi++;
      if (ready && (mem_read || mem_write)) early_ready = 1;
      if (ready) begin
        done = 1; got_hit = hit; got_data = dout; edge_no = cyc - 1;
      end
      if (mem_ready) mem_ready = 0;
      else if (!done && (mem_read || mem_write)) begin
        if (w < delay) w++;
        else begin
          w = 0;
          if (mem_write) begin
            n_wr++; wb_addr = mem_addr; wb_data = mdo;
            for (int k = 0; k < 8; k++) bmem[(int'(mem_addr) + k) % 256] = mdo[k*32 +: 32];
          end else begin
            n_rd++; rd_addr = mem_addr;
            for (int k = 0; k < 8; k++) mdi[k*32 +: 32] = bmem[(int'(mem_addr) + k) % 256];
          end
          mem_ready = 1;
        end
      end
    end
    read = 0; write = 0; mem_ready = 0;
    if (done) begin
      @(negedge clk);
      pulse_ok = !ready;
    end
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    vec++; if ({ready, hit, mem_read, mem_write} !== 4'b0) begin bad++; $display("FAIL reset_ctrl got %b want 0000", {ready, hit, mem_read, mem_write}); end
    vec++; if (mem_addr !== 32'h0 || dout !== '0 || mdo !== '0) begin bad++; $display("FAIL reset_data got addr %h dout %h want 0", mem_addr, dout); end
    rst_n = 1;
  endtask

  task automatic test_cold_read;
    req(32'h04, 1, 0, '0, 0);
    vec++; if (!done) begin bad++; $display("FAIL cold_done got timeout want ready"); end
    vec++; if (n_rd !== 1 || rd_addr !== 32'h00 || n_wr !== 0) begin bad++; $display("FAIL cold_mem got rd %0d@%h wr %0d want rd 1@00 wr 0", n_rd, rd_addr, n_wr); end
    vec++; if (got_hit !== 1'b0) begin bad++; $display("FAIL cold_hit got %b want 0", got_hit); end
    vec++; if (got_data !== w4(104, 105, 106, 107)) begin bad++; $display("FAIL cold_data got %h want %h", got_data, w4(104, 105, 106, 107)); end
    vec++; if (!pulse_ok) begin bad++; $display("FAIL cold_pulse got ready held want one cycle"); end
  endtask

  task automatic test_hit_read;
    req(32'h00, 1, 0, '0, 0);
    vec++; if (n_rd !== 0 || n_wr !== 0) begin bad++; $display("FAIL hit_mem got rd %0d wr %0d want 0 0", n_rd, n_wr); end
    vec++; if (got_hit !== 1'b1) begin bad++; $display("FAIL hit_flag got %b want 1", got_hit); end
    vec++; if (edge_no !== 3) begin bad++; $display("FAIL hit_latency got edge %0d want 3", edge_no); end
    vec++; if (got_data !== w4(100, 101, 102, 103)) begin bad++; $display("FAIL hit_data got %h want %h", got_data, w4(100, 101, 102, 103)); end
  endtask

  task automatic test_dirty_evict;
    req(32'h00, 0, 1, w4(1, 2, 3, 4), 0);
    vec++; if (got_hit !== 1'b1 || n_rd !== 0 || n_wr !== 0) begin bad++; $display("FAIL wr_hit got hit %b rd %0d wr %0d want 1 0 0", got_hit, n_rd, n_wr); end
    req(32'h20, 1, 0, '0, 0);
    vec++; if (n_rd !== 1 || rd_addr !== 32'h20 || n_wr !== 0) begin bad++; $display("FAIL fill20_mem got rd %0d@%h wr %0d want rd 1@20 wr 0", n_rd, rd_addr, n_wr); end
    vec++; if (got_data !== w4(132, 133, 134, 135)) begin bad++; $display("FAIL fill20_data got %h want %h", got_data, w4(132, 133, 134, 135)); end
    req(32'h40, 1, 0, '0, 0);
    vec++; if (n_wr !== 1 || wb_addr !== 32'h00) begin bad++; $display("FAIL evict_wb got wr %0d@%h want 1@00", n_wr, wb_addr); end
    vec++; if (wb_data !== w8(1, 2, 3, 4, 104, 105, 106, 107)) begin bad++; $display("FAIL evict_wbdata got %h want %h", wb_data, w8(1, 2, 3, 4, 104, 105, 106, 107)); end
    vec++; if (n_rd !== 1 || rd_addr !== 32'h40 || got_hit !== 1'b0) begin bad++; $display("FAIL evict_fill got rd %0d@%h hit %b want 1@40 0", n_rd, rd_addr, got_hit); end
    vec++; if (got_data !== w4(164, 165, 166, 167)) begin bad++; $display("FAIL evict_data got %h want %h", got_data, w4(164, 165, 166, 167)); end
  endtask

  task automatic test_rw_both;
    req(32'h20, 1, 1, w4(7, 8, 9, 10), 0);
    vec++; if (got_hit !== 1'b1 || n_rd !== 0 || n_wr !== 0) begin bad++; $display("FAIL rw_hit got hit %b rd %0d wr %0d want 1 0 0", got_hit, n_rd, n_wr); end
    req(32'h00, 1, 0, '0, 0);
    vec++; if (n_wr !== 1 || wb_addr !== 32'h20) begin bad++; $display("FAIL rw_wb got wr %0d@%h want 1@20", n_wr, wb_addr); end
    vec++; if (wb_data !== w8(7, 8, 9, 10, 136, 137, 138, 139)) begin bad++; $display("FAIL rw_wbdata got %h want %h", wb_data, w8(7, 8, 9, 10, 136, 137, 138, 139)); end
    vec++; if (got_data !== w4(1, 2, 3, 4) || got_hit !== 1'b0) begin bad++; $display("FAIL rw_refetch got %h hit %b want %h hit 0", got_data, got_hit, w4(1, 2, 3, 4)); end
  endtask

  task automatic test_long_wait;
    req(32'h08, 1, 0, '0, 20);
    vec++; if (rd_hi !== 21 || n_rd !== 1 || rd_addr !== 32'h08) begin bad++; $display("FAIL wait_rd got held %0d rd %0d@%h want 21 1@08", rd_hi, n_rd, rd_addr); end
    vec++; if (edge_no !== 24 || early_ready) begin bad++; $display("FAIL wait_ready got edge %0d early %b want 24 0", edge_no, early_ready); end
    vec++; if (!pulse_ok) begin bad++; $display("FAIL wait_pulse got ready held want one cycle"); end
    vec++; if (got_data !== w4(108, 109, 110, 111)) begin bad++; $display("FAIL wait_data got %h want %h", got_data, w4(108, 109, 110, 111)); end
  endtask

  task automatic test_reset_mid;
    @(negedge clk);
    addr = 32'h10; read = 1;
    for (int i = 0; i < 50 && !mem_read; i++) @(negedge clk);
    vec++; if (mem_read !== 1'b1) begin bad++; $display("FAIL rstmid_req got mem_read %b want 1", mem_read); end
    rst_n = 0;
    #1;
    vec++; if ({ready, hit, mem_read, mem_write} !== 4'b0 || mem_addr !== 32'h0 || dout !== '0) begin bad++; $display("FAIL rstmid_out got %b addr %h dout %h want 0", {ready, hit, mem_read, mem_write}, mem_addr, dout); end
    read = 0;
    @(negedge clk);
    rst_n = 1;
    req(32'h00, 1, 0, '0, 0);
    vec++; if (got_hit !== 1'b0 || n_rd !== 1 || rd_addr !== 32'h00 || n_wr !== 0) begin bad++; $display("FAIL rstmid_miss got hit %b rd %0d@%h wr %0d want 0 1@00 0", got_hit, n_rd, rd_addr, n_wr); end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog got no finish want finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 256; i++) bmem[i] = 32'(100 + i);
    test_reset;
    test_cold_read;
    test_hit_read;
    test_dirty_evict;
    test_rw_both;
    test_long_wait;
    test_reset_mid;
    $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
    $finish;
  end
endmodule
